mem_port_arbiter: RTL and testbench

- Arbitrates the single physical memory port between the fetch stage (read-only, 32-bit instruction words) and the memory stage (load/store).
- Sequences each access through a request/ready handshake with variable-latency memory.
- Returns read data and a one-cycle ack to the winning requester.
- Enforces data-port priority, with a starvation guard for fetch and a timeout that reports a bus error.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_prio2.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the fetch/data memory-port arbiter:
//   state_e        : arbiter FSM states (IDLE, BUSY, RESP)
//   OWNER_I/OWNER_D: encoding of the access owner (fetch / data)
//   ADDR_W_DEFAULT : default byte-address width
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int unsigned ADDR_W_DEFAULT = 22;

endpackage

// File: rtl/mem_port_arbiter_prio2.sv
// -----------------------------------------------------------------------------
// arb_prio2
// Two-input priority select with a fetch starvation guard. The data input has
// priority; once fetch has lost STARVE_MAX consecutive ties, fetch wins the
// next tie. The starvation counter saturates at STARVE_MAX.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   arb_en_i      : arbitration allowed this cycle (FSM in IDLE)
//   req_i_i       : fetch request
//   req_d_i       : data request
//   gnt_valid_o   : a grant is issued this cycle
//   gnt_owner_o   : owner of the grant (OWNER_I / OWNER_D)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module arb_prio2
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_valid_o,
  output logic gnt_owner_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q == CW'(STARVE_MAX));

  always_comb begin
    gnt_valid_o = arb_en_i & (req_i_i | req_d_i);
    gnt_owner_o = (req_d_i && !(req_i_i && starved)) ? OWNER_D : OWNER_I;

    starve_d = starve_q;
    if (gnt_valid_o) begin
      if (gnt_owner_o == OWNER_I) begin
        starve_d = '0;
      end else if (req_i_i && !starved) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one physical memory port between the fetch stage (read-only) and the
// memory stage (load/store). Each access is sequenced IDLE -> BUSY -> RESP;
// the owner gets a one-cycle ack (with err on timeout) and its read data.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   i_req/i_addr                    : fetch request and byte address
//   i_rdata/i_ack/i_err             : fetch response
//   d_req/d_we/d_addr/d_wstrb/d_wdata : data request
//   d_rdata/d_ack/d_err             : data response
//   mem_valid/mem_we/mem_addr/mem_wstrb/mem_wdata : memory request (registered)
//   mem_rdata/mem_ready             : memory response
//   grant_d                         : owner of current/last access (1 = data)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [TW-1:0]     tmo_q;
  logic              grant_d_q;
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              i_ack_q, d_ack_q;
  logic              i_err_q, d_err_q;

  logic              gnt_valid;
  logic              gnt_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic              tmo_hit;

  arb_prio2 #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   (state_q == IDLE),
    .req_i_i    (i_req),
    .req_d_i    (d_req),
    .gnt_valid_o(gnt_valid),
    .gnt_owner_o(gnt_owner)
  );

  assign sel_addr = (gnt_owner == OWNER_D) ? d_addr : i_addr;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      grant_d_q   <= OWNER_I;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      // Acks and errors are single-cycle pulses raised on entry to RESP.
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            grant_d_q   <= gnt_owner;
            mem_valid_q <= 1'b1;
            mem_we_q    <= (gnt_owner == OWNER_D) & d_we;
            mem_addr_q  <= sel_addr & ~ADDR_W'(3);
            mem_wstrb_q <= (gnt_owner == OWNER_D) ? d_wstrb : '0;
            mem_wdata_q <= (gnt_owner == OWNER_D) ? d_wdata : '0;
            tmo_q       <= '0;
            state_q     <= BUSY;
          end
        end

        BUSY: begin
          if (mem_ready || tmo_hit) begin
            // mem_ready wins over a coincident timeout: the data is real.
            mem_valid_q <= 1'b0;
            state_q     <= RESP;
            if (grant_d_q == OWNER_D) begin
              d_ack_q <= 1'b1;
              d_err_q <= ~mem_ready;
              if (mem_ready && !mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              i_ack_q <= 1'b1;
              i_err_q <= ~mem_ready;
              if (mem_ready) begin
                i_rdata_q <= mem_rdata;
              end
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        RESP: begin
          tmo_q   <= '0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW     = 22;
  localparam int unsigned STARVE = 4;
  localparam int          TMO    = 64;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack, i_err;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ack, d_err;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          grant_d;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .STARVE_MAX(STARVE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wstrb  (d_wstrb),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .d_err    (d_err),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .grant_d  (grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    int            waits;    // memory wait cycles; -1 = never ready
    logic [31:0]   mdata;    // data the memory returns
    int            exp_lat;  // cycles from request to ack
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          mem_waits;
  logic [31:0] mem_data;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic is_d, logic we, logic [AW-1:0] addr,
                              logic [3:0] ws, logic [31:0] wd, int waits,
                              logic [31:0] md, int lat, logic err);
    vec_t v;
    v.nm = nm; v.is_d = is_d; v.we = we; v.addr = addr; v.wstrb = ws;
    v.wdata = wd; v.waits = waits; v.mdata = md; v.exp_lat = lat; v.exp_err = err;
    return v;
  endfunction

  function automatic exp_t mk_exp(logic is_d, logic err, logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.err = err; e.rdata = rdata;
    return e;
  endfunction

  // Memory model: ready after mem_waits BUSY cycles; random noise on
  // mem_ready/mem_rdata while no access is outstanding.
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (mem_waits >= 0 && wcnt == mem_waits) begin
          mem_ready = 1'b1;
          mem_rdata = mem_data;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        wcnt++;
      end else begin
        wcnt      = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Scoreboard consumer: every ack pops the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {62'd0, i_ack, d_ack}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {62'd0, i_ack, d_ack}, e.is_d ? 64'd1 : 64'd2);
          chk("ack_err", e.is_d ? d_err : i_err, e.err);
          chk("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int          cyc;
    bit          got;
    bit          first;
    logic [31:0] r;
    logic [59:0] snap;
    @(negedge clk);
    mem_waits = v.waits;
    mem_data  = v.mdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wstrb = v.wstrb; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    if (v.exp_err || (v.is_d && v.we)) begin
      r = v.is_d ? exp_d_rdata : exp_i_rdata;
    end else begin
      r = v.mdata;
      if (v.is_d) exp_d_rdata = r;
      else        exp_i_rdata = r;
    end
    sb.push_back(mk_exp(v.is_d, v.exp_err, r));

    cyc = 0; got = 0; first = 1;
    snap = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) begin
        got = 1;
      end else if (mem_valid) begin
        if (first) begin
          first = 0;
          snap  = {mem_we, mem_addr, mem_wstrb, mem_wdata, grant_d};
          chk({v.nm, "_addr"}, mem_addr, v.addr & 22'h3FFFFC);
          chk({v.nm, "_wstrb"}, mem_wstrb, v.is_d ? v.wstrb : 4'b0000);
          chk({v.nm, "_we"}, mem_we, v.is_d & v.we);
          chk({v.nm, "_grant"}, grant_d, v.is_d);
          if (v.is_d && v.we) chk({v.nm, "_wdata"}, mem_wdata, v.wdata);
        end else begin
          chk({v.nm, "_stable"}, {mem_we, mem_addr, mem_wstrb, mem_wdata, grant_d}, snap);
        end
      end
    end
    if (!got) begin
      chk({v.nm, "_ack_seen"}, 0, 1);
    end else begin
      chk({v.nm, "_lat"}, cyc, v.exp_lat);
      chk({v.nm, "_valid_in_ack"}, mem_valid, 0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    vec_t        vecs[8];
    int          acks;
    int          cyc;
    int          gap;
    int          ngr;
    bit          second;
    bit          prev_v;
    logic [0:9]  pat;

    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wstrb = '0; d_wdata = '0; mem_waits = -1; mem_data = '0;

    vecs[0] = mk("fetch_zw",   0, 0, 22'h000104, 4'b0000, 32'h0,        0, 32'hDEADBEEF, 2,       0);
    vecs[1] = mk("load_w1",    1, 0, 22'h000040, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 3,       0);
    vecs[2] = mk("store_w3",   1, 1, 22'h000203, 4'b0011, 32'h0000ABCD, 3, 32'h11111111, 5,       0);
    vecs[3] = mk("load_tmo",   1, 0, 22'h000080, 4'b0000, 32'h0,       -1, 32'h22222222, TMO + 1, 1);
    vecs[4] = mk("fetch_w2",   0, 0, 22'h0003FF, 4'b0000, 32'h0,        2, 32'h12345678, 4,       0);
    vecs[5] = mk("fetch_tmo",  0, 0, 22'h000010, 4'b0000, 32'h0,       -1, 32'h33333333, TMO + 1, 1);
    vecs[6] = mk("load_top",   1, 0, 22'h3FFFFE, 4'b0000, 32'h0,        0, 32'h0BADF00D, 2,       0);
    vecs[7] = mk("store_full", 1, 1, 22'h000100, 4'b1111, 32'hFEEDFACE, 0, 32'h44444444, 2,       0);

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_ctl", {mem_valid, mem_we, mem_wstrb, grant_d}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Fetch held high through its ack: the re-request must come from IDLE.
    @(negedge clk);
    i_req = 1'b1; i_addr = 22'h000020; mem_waits = 0; mem_data = 32'h0F0F0F0F;
    sb.push_back(mk_exp(0, 0, 32'h0F0F0F0F));
    sb.push_back(mk_exp(0, 0, 32'h0F0F0F0F));
    exp_i_rdata = 32'h0F0F0F0F;
    acks = 0; cyc = 0; gap = 0; second = 0;
    while (acks < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (i_ack) begin
        acks++;
        if (acks == 2) i_req = 1'b0;
      end
      if (acks == 1 && !second) begin
        if (mem_valid) second = 1;
        else gap++;
      end
    end
    chk("regrant_acks", acks, 2);
    chk("regrant_gap_ge2", gap >= 2, 1);
    i_req = 1'b0;

    // Reset asserted while a load is waiting on memory.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000050; mem_waits = -1;
    repeat (3) @(negedge clk);
    chk("rstmid_busy", mem_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_valid", mem_valid, 0);
    chk("rstmid_acks", {i_ack, d_ack}, 0);
    chk("rstmid_rdata", {i_rdata, d_rdata}, 0);
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_vec(mk("fetch_after_rst", 0, 0, 22'h000444, 4'b0000, 32'h0, 1, 32'hA5A5C3C3, 3, 0));

    // Both ports requesting continuously: fetch wins every fifth arbitration.
    pat = 10'b1111011110;
    for (int k = 0; k < 10; k++) sb.push_back(mk_exp(pat[k], 0, 32'h77770000));
    @(negedge clk);
    i_req = 1'b1; i_addr = 22'h000300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000400; d_wstrb = '0;
    mem_waits = 0; mem_data = 32'h77770000;
    acks = 0; cyc = 0; ngr = 0; prev_v = 0;
    while (acks < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_valid && !prev_v) begin
        if (ngr < 10) chk($sformatf("starve_grant%0d", ngr), grant_d, pat[ngr]);
        ngr++;
      end
      prev_v = mem_valid;
      if (i_ack || d_ack) begin
        acks++;
        if (acks == 10) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    chk("starve_acks", acks, 10);
    i_req = 1'b0;
    d_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("idle_at_end", mem_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
